// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - prioritised interrupt controller with latched pending bits and ack/EOI handshake
module intr_ctrl #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [3:2]       addr_i,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             int_ack,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] irq_prev_q, irq_prev_d;
  logic             gie_q, gie_d;
  logic             int_req_q, int_req_d;
  logic [ID_W-1:0]  int_id_q, int_id_d;
  logic             in_service_q, in_service_d;

  logic [N_SRC-1:0] rise, elig, id_sel, w1c, ack_clr;
  logic [ID_W-1:0]  winner;
  logic             any_elig, sel_elig;
  logic             wr_mask, wr_pend, wr_ctrl, wr_eoi;
  logic             unused_data;

  assign unused_data = ^data_in;

  always_comb begin
    rise     = irq_src & ~irq_prev_q;
    elig     = pend_q & mask_q;
    any_elig = |elig;
    winner   = '0;
    // Scan from the top so the lowest eligible index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end
    for (int i = 0; i < N_SRC; i++) begin
      id_sel[i] = (int_id_q == ID_W'(i));
    end
    sel_elig = |(elig & id_sel);

    wr_mask = we_i && (addr_i == 2'd0);
    wr_pend = we_i && (addr_i == 2'd1);
    wr_ctrl = we_i && (addr_i == 2'd2);
    wr_eoi  = we_i && (addr_i == 2'd3);
    w1c     = wr_pend ? data_in[N_SRC-1:0] : '0;
  end

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;
    ack_clr      = '0;
    irq_prev_d   = irq_src;
    mask_d       = wr_mask ? data_in[N_SRC-1:0] : mask_q;
    gie_d        = wr_ctrl ? data_in[0] : gie_q;

    case (state_q)
      IDLE: begin
        if (gie_q && any_elig) begin
          state_d   = REQ;
          int_id_d  = winner;
          int_req_d = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d      = SERVICE;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          ack_clr      = id_sel;
        end else if (!(gie_q && sel_elig)) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end
      end
      SERVICE: begin
        if (wr_eoi) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        int_req_d = 1'b0;
      end
    endcase

    // New edges win over both software clear and acknowledge clear.
    pend_d = (pend_q & ~w1c & ~ack_clr) | rise;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      pend_q       <= '0;
      irq_prev_q   <= '0;
      gie_q        <= 1'b0;
      int_req_q    <= 1'b0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      pend_q       <= pend_d;
      irq_prev_q   <= irq_prev_d;
      gie_q        <= gie_d;
      int_req_q    <= int_req_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
    end
  end

  always_comb begin
    data_out = '0;
    case (addr_i)
      2'd0: data_out = 32'(mask_q);
      2'd1: data_out = 32'(pend_q);
      2'd2: begin
        data_out[0]          = gie_q;
        data_out[8 +: ID_W]  = int_id_q;
        data_out[16]         = in_service_q;
        data_out[18:17]      = state_q;
      end
      default: begin
        data_out[31]         = in_service_q;
        data_out[ID_W-1:0]   = int_id_q;
      end
    endcase
  end

  assign int_req = int_req_q;
  assign int_id  = int_id_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed self-checking bench for intr_ctrl
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        we_i = 1'b0;
  logic [3:2]  addr_i = 2'd0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [5:0]  irq_src = '0;
  logic        int_ack = 1'b0;
  logic        int_req;
  logic [2:0]  int_id;

  int total = 0;
  int bad = 0;

  intr_ctrl #(.N_SRC(6), .ID_W(3)) dut (
    .clk(clk), .rst_i(rst_i), .we_i(we_i), .addr_i(addr_i), .data_in(data_in),
    .data_out(data_out), .irq_src(irq_src), .int_ack(int_ack),
    .int_req(int_req), .int_id(int_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; data_in = d;
    tick();
    we_i = 1'b0; data_in = '0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    addr_i = a;
    #1;
    v = data_out;
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", int_req); end
    total++; if (int_id !== 3'd0) begin bad++; $display("FAIL reset_id got=%0h exp=0", int_id); end
    read_reg(2'd0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_mask got=%08h exp=00000000", v); end
    read_reg(2'd2, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%08h exp=00000000", v); end
  endtask

  task automatic test_timer_pulse();
    logic [31:0] v;
    bus_write(2'd0, 32'h1);
    bus_write(2'd2, 32'h1);
    irq_src = 6'h01;
    tick();
    irq_src = 6'h00;
    read_reg(2'd1, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL t1_pend got=%08h exp=00000001", v); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL t1_req_early got=%0h exp=0", int_req); end
    tick();
    total++; if (int_req !== 1'b1 || int_id !== 3'd0) begin bad++; $display("FAIL t1_req got=%0h/%0h exp=1/0", int_req, int_id); end
    read_reg(2'd2, v);
    total++; if (v !== 32'h0002_0001) begin bad++; $display("FAIL t1_ctrl_req got=%08h exp=00020001", v); end
    ack_pulse();
    read_reg(2'd2, v);
    total++; if (v !== 32'h0005_0001) begin bad++; $display("FAIL t1_ctrl_svc got=%08h exp=00050001", v); end
    read_reg(2'd3, v);
    total++; if (v !== 32'h8000_0000) begin bad++; $display("FAIL t1_eoi_rd got=%08h exp=80000000", v); end
    read_reg(2'd1, v);
    total++; if (v !== 32'h0 || int_req !== 1'b0) begin bad++; $display("FAIL t1_after_ack got=%08h/%0h exp=0/0", v, int_req); end
    bus_write(2'd3, 32'h0);
    read_reg(2'd2, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL t1_ctrl_idle got=%08h exp=00000001", v); end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    bus_write(2'd0, 32'hFFFF_FFFF);
    read_reg(2'd0, v);
    total++; if (v !== 32'h3F) begin bad++; $display("FAIL t2_mask_upper got=%08h exp=0000003f", v); end
    irq_src = 6'h0A;
    tick();
    irq_src = 6'h00;
    tick();
    total++; if (int_req !== 1'b1 || int_id !== 3'd1) begin bad++; $display("FAIL t2_first got=%0h/%0h exp=1/1", int_req, int_id); end
    ack_pulse();
    read_reg(2'd1, v);
    total++; if (v !== 32'h08) begin bad++; $display("FAIL t2_pend_ack got=%08h exp=00000008", v); end
    bus_write(2'd3, 32'h0);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL t2_req_eoi_edge got=%0h exp=0", int_req); end
    tick();
    total++; if (int_req !== 1'b1 || int_id !== 3'd3) begin bad++; $display("FAIL t2_second got=%0h/%0h exp=1/3", int_req, int_id); end
    read_reg(2'd2, v);
    total++; if (v !== 32'h0002_0301) begin bad++; $display("FAIL t2_ctrl got=%08h exp=00020301", v); end
    ack_pulse();
    bus_write(2'd3, 32'h0);
    read_reg(2'd1, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL t2_pend_end got=%08h exp=00000000", v); end
  endtask

  task automatic test_withdraw();
    logic [31:0] v;
    irq_src = 6'h04;
    tick();
    irq_src = 6'h00;
    tick();
    total++; if (int_req !== 1'b1 || int_id !== 3'd2) begin bad++; $display("FAIL t3_req got=%0h/%0h exp=1/2", int_req, int_id); end
    bus_write(2'd0, 32'h3B);
    tick();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL t3_withdraw got=%0h exp=0", int_req); end
    read_reg(2'd2, v);
    total++; if (v[18:17] !== 2'd0) begin bad++; $display("FAIL t3_state got=%0h exp=0", v[18:17]); end
    read_reg(2'd1, v);
    total++; if (v !== 32'h04) begin bad++; $display("FAIL t3_pend got=%08h exp=00000004", v); end
    bus_write(2'd1, 32'h04);
    bus_write(2'd0, 32'h3F);
    tick();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL t3_no_req got=%0h exp=0", int_req); end
  endtask

  task automatic test_set_wins();
    logic [31:0] v;
    bus_write(2'd2, 32'h0);
    irq_src = 6'h01;
    tick();
    irq_src = 6'h00;
    tick();
    we_i = 1'b1; addr_i = 2'd1; data_in = 32'h1; irq_src = 6'h01;
    tick();
    we_i = 1'b0; data_in = '0;
    read_reg(2'd1, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL t4_set_wins got=%08h exp=00000001", v); end
    irq_src = 6'h00;
    bus_write(2'd1, 32'h1);
    read_reg(2'd1, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL t4_w1c got=%08h exp=00000000", v); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL t4_gie_off got=%0h exp=0", int_req); end
  endtask

  task automatic test_level();
    logic [31:0] v;
    int extra_req;
    bus_write(2'd2, 32'h1);
    irq_src = 6'h10;
    tick();
    tick();
    total++; if (int_req !== 1'b1 || int_id !== 3'd4) begin bad++; $display("FAIL t5_req got=%0h/%0h exp=1/4", int_req, int_id); end
    ack_pulse();
    bus_write(2'd3, 32'h0);
    extra_req = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (int_req !== 1'b0) extra_req++;
    end
    total++; if (extra_req !== 0) begin bad++; $display("FAIL t5_second_req got=%0d exp=0", extra_req); end
    read_reg(2'd1, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL t5_pend got=%08h exp=00000000", v); end
    irq_src = 6'h00;
    tick();
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    irq_src = 6'h20;
    tick();
    irq_src = 6'h00;
    tick();
    ack_pulse();
    irq_src = 6'h02;
    tick();
    irq_src = 6'h00;
    read_reg(2'd2, v);
    total++; if (v !== 32'h0005_0501) begin bad++; $display("FAIL t6_in_svc got=%08h exp=00050501", v); end
    #1;
    rst_i = 1'b1;
    #1;
    total++; if (int_req !== 1'b0 || int_id !== 3'd0) begin bad++; $display("FAIL t6_outs got=%0h/%0h exp=0/0", int_req, int_id); end
    read_reg(2'd1, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL t6_pend got=%08h exp=00000000", v); end
    read_reg(2'd0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL t6_mask got=%08h exp=00000000", v); end
    read_reg(2'd2, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL t6_ctrl got=%08h exp=00000000", v); end
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    test_reset();
    test_timer_pulse();
    test_priority();
    test_withdraw();
    test_set_wins();
    test_level();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
